// File: rtl/vproc_hazard_scoreboard.sv
// rtl/vproc_hazard_scoreboard.sv - in-flight vector instruction hazard scoreboard (RAW/WAR/WAW stall)
// Optional same-cycle release/retire bypass: define VPROC_HAZARD_SCOREBOARD_BYPASS_EN.
module vproc_hazard_scoreboard #(
  parameter int VREG_CNT  = 32,
  parameter int SLOT_CNT  = 4,
  parameter int RET_PORTS = 2,
  parameter int ID_W      = $clog2(SLOT_CNT)
) (
  input  logic                      clk_i,
  input  logic                      async_rst_i,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [VREG_CNT-1:0]       issue_rd_mask_i,
  input  logic [VREG_CNT-1:0]       issue_wr_mask_i,
  output logic [ID_W-1:0]           issue_id_o,
  input  logic [RET_PORTS-1:0]      rel_valid_i,
  input  logic [RET_PORTS*ID_W-1:0] rel_id_i,
  input  logic [RET_PORTS-1:0]      ret_valid_i,
  input  logic [RET_PORTS*ID_W-1:0] ret_id_i,
  output logic [VREG_CNT-1:0]       pend_rd_o,
  output logic [VREG_CNT-1:0]       pend_wr_o,
  output logic [ID_W:0]             busy_cnt_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      err_o
);

  logic [SLOT_CNT-1:0] busy_q;
  logic [VREG_CNT-1:0] rd_q [SLOT_CNT];
  logic [VREG_CNT-1:0] wr_q [SLOT_CNT];
  logic [VREG_CNT-1:0] pend_rd_q, pend_wr_q;
  logic [ID_W:0]       busy_cnt_q;
  logic                err_q;

  logic [SLOT_CNT-1:0] ret_hit, rel_hit;
  logic                err_set;

  // Ports naming a non-busy slot are ignored and flag a protocol error.
  always_comb begin
    ret_hit = '0;
    rel_hit = '0;
    err_set = 1'b0;
    for (int p = 0; p < RET_PORTS; p++) begin
      if (ret_valid_i[p]) begin
        if (busy_q[ret_id_i[p*ID_W +: ID_W]]) ret_hit[ret_id_i[p*ID_W +: ID_W]] = 1'b1;
        else err_set = 1'b1;
      end
      if (rel_valid_i[p]) begin
        if (busy_q[rel_id_i[p*ID_W +: ID_W]]) rel_hit[rel_id_i[p*ID_W +: ID_W]] = 1'b1;
        else err_set = 1'b1;
      end
    end
  end

  logic [SLOT_CNT-1:0] busy_v;
  logic [VREG_CNT-1:0] rd_v [SLOT_CNT];
  logic [VREG_CNT-1:0] wr_v [SLOT_CNT];

  always_comb begin
    busy_v = busy_q & ~ret_hit;
    for (int s = 0; s < SLOT_CNT; s++) begin
      rd_v[s] = (ret_hit[s] | rel_hit[s]) ? '0 : rd_q[s];
      wr_v[s] = ret_hit[s] ? '0 : wr_q[s];
    end
  end

  logic [SLOT_CNT-1:0] chk_busy;
  logic [VREG_CNT-1:0] chk_rd, chk_wr;

`ifdef VPROC_HAZARD_SCOREBOARD_BYPASS_EN
  logic [VREG_CNT-1:0] view_rd, view_wr;

  always_comb begin
    view_rd = '0;
    view_wr = '0;
    for (int s = 0; s < SLOT_CNT; s++) begin
      view_rd = view_rd | rd_v[s];
      view_wr = view_wr | wr_v[s];
    end
  end

  assign chk_busy = busy_v;
  assign chk_rd   = view_rd;
  assign chk_wr   = view_wr;
`else
  assign chk_busy = busy_q;
  assign chk_rd   = pend_rd_q;
  assign chk_wr   = pend_wr_q;
`endif

  logic [ID_W-1:0] alloc_id;
  logic            alloc_found;

  always_comb begin
    alloc_id    = '0;
    alloc_found = 1'b0;
    for (int s = 0; s < SLOT_CNT; s++) begin
      if (!chk_busy[s] && !alloc_found) begin
        alloc_id    = ID_W'(s);
        alloc_found = 1'b1;
      end
    end
  end

  logic conflict, accept;

  assign conflict = |(issue_rd_mask_i & chk_wr) |
                    |(issue_wr_mask_i & chk_rd) |
                    |(issue_wr_mask_i & chk_wr);
  assign issue_ready_o = !async_rst_i && alloc_found && !conflict;
  assign accept        = issue_valid_i && issue_ready_o;
  assign issue_id_o    = alloc_id;

  logic [SLOT_CNT-1:0] busy_n;
  logic [VREG_CNT-1:0] rd_n [SLOT_CNT];
  logic [VREG_CNT-1:0] wr_n [SLOT_CNT];
  logic [VREG_CNT-1:0] pend_rd_n, pend_wr_n;
  logic [ID_W:0]       cnt_n;

  // Accept wins over a same-cycle retire of the slot (only reachable with bypass).
  always_comb begin
    busy_n = busy_v;
    for (int s = 0; s < SLOT_CNT; s++) begin
      rd_n[s] = rd_v[s];
      wr_n[s] = wr_v[s];
    end
    if (accept) begin
      busy_n[alloc_id] = 1'b1;
      rd_n[alloc_id]   = issue_rd_mask_i;
      wr_n[alloc_id]   = issue_wr_mask_i;
    end
    pend_rd_n = '0;
    pend_wr_n = '0;
    cnt_n     = '0;
    for (int s = 0; s < SLOT_CNT; s++) begin
      pend_rd_n = pend_rd_n | rd_n[s];
      pend_wr_n = pend_wr_n | wr_n[s];
      cnt_n     = cnt_n + (ID_W+1)'(busy_n[s]);
    end
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      busy_q     <= '0;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
      for (int s = 0; s < SLOT_CNT; s++) begin
        rd_q[s] <= '0;
        wr_q[s] <= '0;
      end
    end else begin
      busy_q     <= busy_n;
      pend_rd_q  <= pend_rd_n;
      pend_wr_q  <= pend_wr_n;
      busy_cnt_q <= cnt_n;
      err_q      <= err_q | err_set;
      for (int s = 0; s < SLOT_CNT; s++) begin
        rd_q[s] <= rd_n[s];
        wr_q[s] <= wr_n[s];
      end
    end
  end

  assign pend_rd_o  = pend_rd_q;
  assign pend_wr_o  = pend_wr_q;
  assign busy_cnt_o = busy_cnt_q;
  assign full_o     = (busy_cnt_q == (ID_W+1)'(SLOT_CNT));
  assign empty_o    = (busy_cnt_q == '0);
  assign err_o      = err_q;

endmodule

// File: tb/tb_vproc_hazard_scoreboard.sv
// tb/tb_vproc_hazard_scoreboard.sv - directed and randomized checks of vproc_hazard_scoreboard against a slot-table model
module tb_vproc_hazard_scoreboard;
  localparam int VREG  = 32;
  localparam int SLOTS = 4;
  localparam int PORTS = 2;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  issue_valid;
  logic                  ready;
  logic [VREG-1:0]       irm, iwm;
  logic [IDW-1:0]        iid;
  logic [PORTS-1:0]      relv, retv;
  logic [PORTS*IDW-1:0]  relid, retid;
  logic [VREG-1:0]       prd, pwr;
  logic [IDW:0]          bcnt;
  logic                  full, empty, err;

  int total = 0;
  int bad   = 0;

  bit              mbusy [SLOTS];
  logic [VREG-1:0] mrd   [SLOTS];
  logic [VREG-1:0] mwr   [SLOTS];
  bit              merr;
  bit              last_acc;
  int              last_id;

  always #5 clk = ~clk;

  vproc_hazard_scoreboard #(
    .VREG_CNT (VREG),
    .SLOT_CNT (SLOTS),
    .RET_PORTS(PORTS)
  ) dut (
    .clk_i          (clk),
    .async_rst_i    (rst),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (ready),
    .issue_rd_mask_i(irm),
    .issue_wr_mask_i(iwm),
    .issue_id_o     (iid),
    .rel_valid_i    (relv),
    .rel_id_i       (relid),
    .ret_valid_i    (retv),
    .ret_id_i       (retid),
    .pend_rd_o      (prd),
    .pend_wr_o      (pwr),
    .busy_cnt_o     (bcnt),
    .full_o         (full),
    .empty_o        (empty),
    .err_o          (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VREG-1:0] m_pend_rd();
    logic [VREG-1:0] r = '0;
    for (int s = 0; s < SLOTS; s++) if (mbusy[s]) r |= mrd[s];
    return r;
  endfunction

  function automatic logic [VREG-1:0] m_pend_wr();
    logic [VREG-1:0] r = '0;
    for (int s = 0; s < SLOTS; s++) if (mbusy[s]) r |= mwr[s];
    return r;
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int s = 0; s < SLOTS; s++) n += int'(mbusy[s]);
    return n;
  endfunction

  function automatic int m_free();
    for (int s = 0; s < SLOTS; s++) if (!mbusy[s]) return s;
    return -1;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SLOTS; s++) begin
      mbusy[s] = 0;
      mrd[s]   = '0;
      mwr[s]   = '0;
    end
    merr = 0;
  endfunction

  // Apply one clock edge of retire/release/accept to the slot table.
  function automatic void m_update(input bit acc, input int id);
    bit kill [SLOTS];
    int k;
    for (int s = 0; s < SLOTS; s++) kill[s] = 0;
    for (int p = 0; p < PORTS; p++) begin
      if (retv[p]) begin
        k = int'(retid[p*IDW +: IDW]);
        if (!mbusy[k]) merr = 1; else kill[k] = 1;
      end
      if (relv[p]) begin
        k = int'(relid[p*IDW +: IDW]);
        if (!mbusy[k]) merr = 1; else mrd[k] = '0;
      end
    end
    for (int s = 0; s < SLOTS; s++) if (kill[s]) begin
      mbusy[s] = 0;
      mrd[s]   = '0;
      mwr[s]   = '0;
    end
    if (acc) begin
      mbusy[id] = 1;
      mrd[id]   = irm;
      mwr[id]   = iwm;
    end
  endfunction

  task automatic check_regs();
    chk("pend_rd", prd, m_pend_rd());
    chk("pend_wr", pwr, m_pend_wr());
    chk("busy_cnt", bcnt, m_cnt());
    chk("full", full, m_cnt() == SLOTS);
    chk("empty", empty, m_cnt() == 0);
    chk("err", err, merr);
  endtask

  task automatic step();
    bit exp_ready;
    int fid;
    logic [VREG-1:0] hz;
    #1;
    fid = m_free();
    hz  = (irm & m_pend_wr()) | (iwm & m_pend_rd()) | (iwm & m_pend_wr());
    exp_ready = (fid >= 0) && (hz == '0);
    chk("ready", ready, exp_ready);
    if (issue_valid && exp_ready) chk("issue_id", iid, fid);
    last_acc = issue_valid && exp_ready;
    last_id  = fid;
    @(posedge clk);
    m_update(last_acc, fid);
    #1;
    check_regs();
  endtask

  task automatic drive(input bit v, input logic [VREG-1:0] rd, input logic [VREG-1:0] wr);
    issue_valid = v;
    irm = rd;
    iwm = wr;
  endtask

  task automatic set_ret(input int p, input bit v, input int id);
    retv[p] = v;
    retid[p*IDW +: IDW] = IDW'(id);
  endtask

  task automatic set_rel(input int p, input bit v, input int id);
    relv[p] = v;
    relid[p*IDW +: IDW] = IDW'(id);
  endtask

  task automatic reset_checks();
    chk("rst_pend_rd", prd, 0);
    chk("rst_pend_wr", pwr, 0);
    chk("rst_busy_cnt", bcnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", ready, 0);
    chk("rst_id", iid, 0);
  endtask

  task automatic do_reset();
    drive(0, '0, '0);
    relv = '0; retv = '0; relid = '0; retid = '0;
    rst = 1'b1;
    #1;
    reset_checks();
    @(negedge clk);
    rst = 1'b0;
    m_clear();
  endtask

  function automatic logic [VREG-1:0] rand_mask();
    logic [VREG-1:0] m = '0;
    if ($urandom_range(0, 3) != 0) begin
      m[$urandom_range(0, 7)] = 1'b1;
      if ($urandom_range(0, 1) == 1) m[$urandom_range(0, 7)] = 1'b1;
    end
    return m;
  endfunction

  initial begin
    int id;
    m_clear();
    do_reset();

    // accept into slot 0, then RAW stall cleared by retire one cycle later
    drive(1, 32'h6, 32'h1); step();
    chk("t1_acc_id", last_id, 0);
    chk("t1_pend_rd", prd, 32'h6);
    chk("t1_pend_wr", pwr, 32'h1);
    drive(1, 32'h1, 32'h0); set_ret(0, 1, 0); step();
    chk("t2_stalled", last_acc, 0);
    set_ret(0, 0, 0); step();
    chk("t2_acc", last_acc, 1);
    drive(0, '0, '0); step();

    // WAR stall released by operand release, new id 1
    do_reset();
    drive(1, 32'h6, 32'h0); step();
    drive(1, 32'h0, 32'h4); set_rel(0, 1, 0); step();
    chk("t3_pend_rd", prd, 32'h0);
    set_rel(0, 0, 0); step();
    chk("t3_acc", last_acc, 1);
    chk("t3_id", last_id, 1);

    // fill, full stall, dual-port retire, reuse lowest free
    do_reset();
    for (int i = 0; i < SLOTS; i++) begin
      drive(1, '0, 32'h1 << i); step();
    end
    drive(1, '0, '0); step();
    chk("t4_full", full, 1);
    drive(0, '0, '0); set_ret(0, 1, 1); set_ret(1, 1, 3); step();
    chk("t4_cnt", bcnt, 2);
    set_ret(0, 0, 0); set_ret(1, 0, 0);
    drive(1, '0, 32'h100); step();
    chk("t4_id", last_id, 1);

    // retire of a free slot sets sticky error
    do_reset();
    set_ret(0, 1, 2); step();
    set_ret(0, 0, 0); step(); step();
    chk("t5_err", err, 1);

    // async reset during a stall with three busy slots
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, '0, 32'h1 << i); step();
    end
    drive(1, 32'h1, '0); step();
    #2;
    rst = 1'b1;
    #1;
    reset_checks();
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    drive(0, '0, '0);
    step();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 0) do_reset();
      drive($urandom_range(0, 3) != 0, rand_mask(), rand_mask());
      for (int p = 0; p < PORTS; p++) begin
        id = $urandom_range(0, SLOTS-1);
        set_ret(p, ($urandom_range(0, 2) == 0) && (mbusy[id] || $urandom_range(0, 15) == 0), id);
        id = $urandom_range(0, SLOTS-1);
        set_rel(p, ($urandom_range(0, 3) == 0) && (mbusy[id] || $urandom_range(0, 15) == 0), id);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vproc_hazard_scoreboard.md
# vproc_hazard_scoreboard

Sequential successor to the combinational vector-register hazard mask generator. It keeps a table of in-flight vector instructions with their read and write register masks. It stalls a new instruction at issue while it has a RAW, WAR or WAW conflict with anything pending. It frees resources as execution units release operands and retire instructions, and sits between the decoder's hazard mask generation and the unit dispatch queues.

## Interface
Parameters:
- VREG_CNT, 32, number of vector registers (mask width).
- SLOT_CNT, 4, in-flight instruction slots (power of two, 2..16).
- RET_PORTS, 2, number of independent retire/release ports (1..4).
- ID_W, $clog2(SLOT_CNT), slot id width (derived, not overridden).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock, all state on rising edge.
- async_rst_i  in  1  asynchronous reset, active-high.
- issue_valid_i  in  1  decoder offers an instruction.
- issue_ready_o  out  1  instruction accepted this cycle when high with valid.
- issue_rd_mask_i  in  VREG_CNT  registers the instruction reads.
- issue_wr_mask_i  in  VREG_CNT  registers the instruction writes.
- issue_id_o  out  ID_W  slot allocated to the accepted instruction.
- rel_valid_i  in  RET_PORTS  per port: operands of slot rel_id_i read; clear its read mask.
- rel_id_i  in  RET_PORTS*ID_W  slot ids for release.
- ret_valid_i  in  RET_PORTS  per port: slot retired; clear both masks and free the slot.
- ret_id_i  in  RET_PORTS*ID_W  slot ids for retire.
- pend_rd_o  out  VREG_CNT  OR of read masks of busy slots (registered).
- pend_wr_o  out  VREG_CNT  OR of write masks of busy slots (registered).
- busy_cnt_o  out  ID_W+1  number of busy slots.
- full_o / empty_o  out  1  busy_cnt_o == SLOT_CNT / == 0.
- err_o  out  1  sticky protocol error flag.

## Operation
- Per slot state: busy bit, rd mask, wr mask. Free slot → Busy on accept. Busy → Free on retire. Release changes only the rd mask.
- Conflict = (issue_rd & pend_wr) | (issue_wr & pend_rd) | (issue_wr & pend_wr), each term non-zero.
- issue_ready_o = !full_o & !conflict. It depends combinationally on the issue masks and does not depend on issue_valid_i.
- Allocation: lowest-index free slot. issue_id_o is valid in the cycle of acceptance.
- On accept, the slot captures both masks. A zero-mask instruction still occupies a slot.
- Release or retire of a non-busy slot: ignored, err_o set (sticky until reset). Release after retire of the same slot in the same cycle: retire wins, no error.
- Multiple ports naming the same slot in one cycle: idempotent, no error.
- Retire and accept in the same cycle are both applied. A slot freed this cycle is not reallocated before the next cycle unless the bypass is compiled in.
- busy_cnt_o next = current + accept − number of distinct busy slots retired.

## Timing
- Reset values: all slots free, masks zero, pend_rd_o = pend_wr_o = 0, busy_cnt_o = 0, empty_o = 1, full_o = 0, err_o = 0, issue_id_o = 0.
- Reset asserted mid-operation clears all slots immediately, regardless of the clock. issue_ready_o is low while reset is high.
- Accept at edge N: the slot is busy and pend_* include its masks from N+1.
- Release or retire at edge N: the masks are removed from pend_* at N+1. Without bypass, a blocked instruction is accepted at the earliest at edge N+1.
- Handshake: the decoder holds valid and masks stable until ready. The block tolerates mask changes while not ready and re-evaluates them every cycle.

## Configuration
- VPROC_HAZARD_SCOREBOARD_BYPASS_EN defined: the conflict check and allocation use the post-release/retire view of the current cycle. A blocked instruction whose hazard clears via a retire at edge N is accepted at edge N. A slot retired in the cycle may be reallocated in the same cycle.
- Undefined: the check uses registered state only, which gives one extra cycle of stall after release or retire and a shorter combinational path.

## Test plan
- Issue rd=0x6, wr=0x1 after reset → accepted, id 0. Next cycle pend_rd=0x6, pend_wr=0x1, busy_cnt=1.
- With slot 0 pending wr=0x1, issue rd=0x1 (RAW) → ready low. Retire id 0 at edge N → accepted at N+1 (no bypass) or N (bypass).
- Slot 0 pending rd=0x6; issue wr=0x4 (WAR) stalls. Release id 0 → pend_rd=0. The instruction is accepted next cycle and gets id 1 while slot 0 is still busy.
- Fill 4 non-conflicting instructions → full_o=1, ready low. Retire ids 1 and 3 together on two ports → busy_cnt=2, and the next issue gets id 1.
- Retire id 2 while slot 2 is free → err_o=1 and stays 1; no state change.
- Assert async_rst_i mid-stall with 3 busy slots → all outputs return to reset values before the next clock edge.
